// File: rtl/alu_shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// The ALU control logic imports the same op encodings to drive the op input.
package alu_shift_sequencer_pkg;

  // Shift type encodings; 2'b11 is reserved and shifts like SRL
  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_shift_sequencer_shift_step.sv
// Single-step shifter: moves the data word by 4 or by 1 bit position.
// SRL and the reserved op fill with zeros from the top, SLL fills with
// zeros from the bottom, SRA fills from the top with the supplied sign bit.
module shift_step
  import alu_shift_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] data_in,
  input  logic [1:0]   op,
  input  logic         by4,
  input  logic         sign_bit,
  output logic [N-1:0] data_out
);

  // Pick the shifted word for the requested direction, distance and fill
  always_comb begin
    data_out = data_in;
    case (op)
      OP_SLL: begin
        if (by4) data_out = {data_in[N-5:0], 4'b0000};
        else     data_out = {data_in[N-2:0], 1'b0};
      end
      OP_SRA: begin
        if (by4) data_out = {{4{sign_bit}}, data_in[N-1:4]};
        else     data_out = {sign_bit, data_in[N-1:1]};
      end
      default: begin
        if (by4) data_out = {4'b0000, data_in[N-1:4]};
        else     data_out = {1'b0, data_in[N-1:1]};
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift controller beside the lab ALU. A start loads the
// operand, shift amount and type, then one shift_step per cycle (by 4
// while at least 4 positions remain, else by 1) walks the data register
// to the final result. Z is the data register itself; done pulses once.
module alu_shift_sequencer
  import alu_shift_sequencer_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [SHW-1:0] shamt,
  input  logic [1:0]     op,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   Z
);

  state_t         state_q, state_d;
  logic [N-1:0]   data_q, data_d;
  logic [SHW-1:0] rem_q, rem_d;
  logic [1:0]     op_q, op_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           by4;
  logic [N-1:0]   step_out;

  // Take the big step whenever at least four positions are still owed
  assign by4 = (rem_q >= SHW'(4));

  // During SRA the top bit of the data register is always the original
  // sign bit, since every step refills it with itself
  shift_step #(.N(N)) u_step (
    .data_in  (data_q),
    .op       (op_q),
    .by4      (by4),
    .sign_bit (data_q[N-1]),
    .data_out (step_out)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        data_d = step_out;
        rem_d  = by4 ? (rem_q - SHW'(4)) : (rem_q - SHW'(1));
        if (rem_d == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        if (start) begin
          data_d = A;
          rem_d  = shamt;
          op_d   = op;
          if (shamt != '0) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any shift in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= OP_SRL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Z    = data_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer at N=32.
// Expected results come from a reference shift model and are queued at
// launch, then popped and compared when done is observed.
module tb_alu_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] Z;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] z;
    int          lat;
    int          bz;
  } exp_t;

  exp_t sb[$];

  alu_shift_sequencer #(.N(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .shamt (shamt),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .Z     (Z)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result built from the language shift operators
  function automatic logic [31:0] model_z(input logic [31:0] a, input int s, input logic [1:0] o);
    logic signed [31:0] sa;
    sa = a;
    case (o)
      2'b01:   return a << s;
      2'b10:   return sa >>> s;
      default: return a >> s;
    endcase
  endfunction

  // Drive one start cycle from a negedge and queue the expected outcome
  task automatic launch(input logic [31:0] a, input int s, input logic [1:0] o);
    exp_t e;
    int   steps;
    steps = s / 4 + s % 4;
    e.z   = model_z(a, s, o);
    e.lat = steps + 1;
    e.bz  = steps;
    sb.push_back(e);
    start = 1'b1;
    A     = a;
    shamt = 5'(s);
    op    = o;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    shamt = 5'($urandom_range(0, 31));
    op    = 2'($urandom_range(0, 3));
  endtask

  // Wait (bounded) for done, counting negedges since the accepting edge
  task automatic wait_done(input int k0, output int lat, output int bcnt,
                           output bit overlap, output bit to);
    int k;
    k = k0;
    bcnt = 0;
    overlap = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
      k++;
    end
    lat = k;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    total++; if (Z !== 32'h0) begin bad++; $display("[TB] FAIL reset_z: got %h want 00000000", Z); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_shift_types();
    logic [31:0] ta [5] = '{32'hF0000000, 32'h80000000, 32'h40000000, 32'h00000001, 32'h00000100};
    int          ts [5] = '{7, 31, 30, 4, 8};
    logic [1:0]  to_[5] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
    logic [31:0] tz [5] = '{32'h01E00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000010, 32'h00000001};
    exp_t e;
    int lat, bcnt;
    bit ov, to;
    for (int i = 0; i < 5; i++) begin
      launch(ta[i], ts[i], to_[i]);
      wait_done(1, lat, bcnt, ov, to);
      e = sb.pop_front();
      total++; if (to) begin bad++; $display("[TB] FAIL types_timeout[%0d]: done never seen, want within %0d cycles", i, e.lat); end
      total++; if (Z !== tz[i] || Z !== e.z) begin bad++; $display("[TB] FAIL types_z[%0d]: got %h want %h", i, Z, tz[i]); end
      total++; if (lat !== e.lat) begin bad++; $display("[TB] FAIL types_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      total++; if (bcnt !== e.bz) begin bad++; $display("[TB] FAIL types_busy_cycles[%0d]: got %0d want %0d", i, bcnt, e.bz); end
      total++; if (ov) begin bad++; $display("[TB] FAIL types_busy_done_overlap[%0d]: got 1 want 0", i); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL types_done_pulse[%0d]: got %b want 0", i, done); end
    end
  endtask

  task automatic test_zero_shift();
    exp_t e;
    int lat, bcnt;
    bit ov, to;
    launch(32'h12345678, 0, 2'b00);
    wait_done(1, lat, bcnt, ov, to);
    e = sb.pop_front();
    total++; if (to || lat !== 1) begin bad++; $display("[TB] FAIL zero_latency: got %0d (timeout %0b) want 1", lat, to); end
    total++; if (bcnt !== 0) begin bad++; $display("[TB] FAIL zero_busy: got %0d busy cycles want 0", bcnt); end
    total++; if (Z !== e.z) begin bad++; $display("[TB] FAIL zero_z: got %h want %h", Z, e.z); end
    repeat (3) @(negedge clk);
    total++; if (Z !== 32'h12345678) begin bad++; $display("[TB] FAIL zero_hold: got %h want 12345678", Z); end
  endtask

  task automatic test_ignore_busy();
    exp_t e;
    int lat, bcnt, dcnt;
    bit ov, to;
    launch(32'hF0000000, 7, 2'b00);
    @(negedge clk);
    start = 1'b1;
    A     = 32'hFFFFFFFF;
    shamt = 5'd0;
    op    = 2'b01;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, bcnt, ov, to);
    e = sb.pop_front();
    total++; if (to || lat !== e.lat) begin bad++; $display("[TB] FAIL ignore_latency: got %0d (timeout %0b) want %0d", lat, to, e.lat); end
    total++; if (Z !== e.z) begin bad++; $display("[TB] FAIL ignore_z: got %h want %h", Z, e.z); end
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    total++; if (dcnt !== 0) begin bad++; $display("[TB] FAIL ignore_extra_done: got %0d pulses want 0", dcnt); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat, bcnt;
    bit ov, to;
    launch(32'h80000000, 5, 2'b10);
    wait_done(1, lat, bcnt, ov, to);
    e = sb.pop_front();
    total++; if (to || Z !== e.z) begin bad++; $display("[TB] FAIL b2b_first_z: got %h want %h", Z, e.z); end
    launch(32'h00000003, 6, 2'b01);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", done, busy); end
    wait_done(1, lat, bcnt, ov, to);
    e = sb.pop_front();
    total++; if (to || lat !== e.lat) begin bad++; $display("[TB] FAIL b2b_second_latency: got %0d want %0d", lat, e.lat); end
    total++; if (Z !== e.z) begin bad++; $display("[TB] FAIL b2b_second_z: got %h want %h", Z, e.z); end
    launch(32'h0000ABCD, 0, 2'b00);
    e = sb.pop_front();
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_zero_done: got done=%b busy=%b want done=1 busy=0", done, busy); end
    total++; if (Z !== e.z) begin bad++; $display("[TB] FAIL b2b_zero_z: got %h want %h", Z, e.z); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_abort();
    exp_t e;
    int lat, bcnt, dcnt;
    bit ov, to;
    launch(32'h80000000, 31, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL abort_flags: got busy=%b done=%b want 0 0", busy, done); end
    total++; if (Z !== 32'h0) begin bad++; $display("[TB] FAIL abort_z: got %h want 00000000", Z); end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    total++; if (dcnt !== 0) begin bad++; $display("[TB] FAIL abort_quiet: got %0d active cycles want 0", dcnt); end
    launch(32'h80000001, 1, 2'b10);
    wait_done(1, lat, bcnt, ov, to);
    e = sb.pop_front();
    total++; if (to || lat !== e.lat) begin bad++; $display("[TB] FAIL abort_resume_latency: got %0d want %0d", lat, e.lat); end
    total++; if (Z !== e.z) begin bad++; $display("[TB] FAIL abort_resume_z: got %h want %h", Z, e.z); end
  endtask

  // Run every scenario in order, then report
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    shamt = '0;
    op    = '0;
    test_reset();
    test_shift_types();
    test_zero_shift();
    test_ignore_busy();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
